// File: rtl/mem_wb_buf_pkg.sv
// mem_wb_buf_pkg: shared limits and reset constants for the MEM/WB write-back buffer.
`default_nettype none

package mem_wb_buf_pkg;

    localparam int          MEMWB_DEPTH_MAX = 4;
    localparam int          MEMWB_CH_MAX    = 4;

    localparam logic [4:0]  NOPRegAddr      = 5'b00000;
    localparam logic [31:0] ZeroWord        = 32'h0000_0000;
    localparam logic        WriteDisable    = 1'b0;

endpackage : mem_wb_buf_pkg

`default_nettype wire

// File: rtl/pipe_fifo_ctrl.sv
// pipe_fifo_ctrl: read/write pointers and occupancy counter for a DEPTH-entry circular buffer.
`default_nettype none

module pipe_fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_cnt == c_FULL);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_cnt    = r_cnt;

endmodule : pipe_fifo_ctrl

`default_nettype wire

// File: rtl/mem_wb_buf.sv
// mem_wb_buf: MEM/WB stage as a small in-order multi-channel buffer with valid/ready write-back.
`default_nettype none

module mem_wb_buf
    import mem_wb_buf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 2,
    parameter int STALL_BIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 stall,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   in_wd,
    input  logic [NUM_CH-1:0]          in_wreg,
    input  logic [NUM_CH*DATA_W-1:0]   in_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*ADDR_W-1:0]   out_wd,
    output logic [NUM_CH-1:0]          out_wreg,
    output logic [NUM_CH*DATA_W-1:0]   out_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stallreq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]         w_wr_ptr;
    logic [PTR_W-1:0]         w_rd_ptr;
    logic [CNT_W-1:0]         w_cnt;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;

    logic [NUM_CH*ADDR_W-1:0] r_wd    [DEPTH];
    logic [NUM_CH-1:0]        r_wreg  [DEPTH];
    logic [NUM_CH*DATA_W-1:0] r_wdata [DEPTH];

    // in_ready depends only on registered state, stall and flush, never on out_ready.
    assign in_ready = !w_full && !stall[STALL_BIT] && !flush;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && out_ready && !flush;

    pipe_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (flush),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_cnt    (w_cnt),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_wd[i]    <= {NUM_CH{ADDR_W'(NOPRegAddr)}};
                r_wreg[i]  <= {NUM_CH{WriteDisable}};
                r_wdata[i] <= {NUM_CH{DATA_W'(ZeroWord)}};
            end
        end else if (w_push) begin
            r_wd[w_wr_ptr]    <= in_wd;
            r_wreg[w_wr_ptr]  <= in_wreg;
            r_wdata[w_wr_ptr] <= in_wdata;
        end
    end

    assign out_valid = !w_empty;
    assign out_wd    = r_wd[w_rd_ptr];
    assign out_wdata = r_wdata[w_rd_ptr];
    // An empty buffer must never raise a register-file write enable.
    assign out_wreg  = out_valid ? r_wreg[w_rd_ptr] : {NUM_CH{WriteDisable}};
    assign count     = w_cnt;
    assign stallreq  = w_full;

endmodule : mem_wb_buf

`default_nettype wire

// File: tb/tb_mem_wb_buf.sv
// tb_mem_wb_buf: queue-model scoreboard for mem_wb_buf at DEPTH=2 and DEPTH=3 driven by shared stimulus.
`default_nettype none

module tb_mem_wb_buf;

    typedef struct packed {
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
    } ent_t;

    localparam int DEP [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [9:0]  in_wd = '0;
    logic [1:0]  in_wreg = '0;
    logic [63:0] in_wdata = '0;

    logic        o_in_ready  [2];
    logic        o_out_valid [2];
    logic [9:0]  o_wd        [2];
    logic [1:0]  o_wreg      [2];
    logic [63:0] o_wdata     [2];
    logic [1:0]  o_count     [2];
    logic        o_stallreq  [2];

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t q [2][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_wb_buf #(
            .DATA_W (32),
            .ADDR_W (5),
            .NUM_CH (2),
            .DEPTH  (DEP[g]),
            .STALL_BIT (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .stall     (stall),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (o_in_ready[g]),
            .in_wd     (in_wd),
            .in_wreg   (in_wreg),
            .in_wdata  (in_wdata),
            .out_valid (o_out_valid[g]),
            .out_ready (out_ready),
            .out_wd    (o_wd[g]),
            .out_wreg  (o_wreg[g]),
            .out_wdata (o_wdata[g]),
            .count     (o_count[g]),
            .stallreq  (o_stallreq[g])
        );
    end

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth=%0d t=%0t actual=%h required=%h", name, DEP[inst], $time, act, exp);
        end
    endtask

    // Reference model: a bounded FIFO of whole entries, checked mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                chk("rst_out_valid", i, 64'(o_out_valid[i]), 64'd0);
                chk("rst_out_wreg",  i, 64'(o_wreg[i]),      64'd0);
                chk("rst_out_wd",    i, 64'(o_wd[i]),        64'd0);
                chk("rst_out_wdata", i, o_wdata[i],          64'd0);
                chk("rst_count",     i, 64'(o_count[i]),     64'd0);
                chk("rst_stallreq",  i, 64'(o_stallreq[i]),  64'd0);
                q[i].delete();
            end else begin
                automatic int   sz  = q[i].size();
                automatic logic rdy = (sz != DEP[i]) && !stall[4] && !flush;
                chk("in_ready",  i, 64'(o_in_ready[i]),  64'(rdy));
                chk("count",     i, 64'(o_count[i]),     64'(sz));
                chk("stallreq",  i, 64'(o_stallreq[i]),  64'(sz == DEP[i]));
                chk("out_valid", i, 64'(o_out_valid[i]), 64'(sz != 0));
                if (sz != 0) begin
                    chk("out_wd",    i, 64'(o_wd[i]),   64'(q[i][0].wd));
                    chk("out_wreg",  i, 64'(o_wreg[i]), 64'(q[i][0].wreg));
                    chk("out_wdata", i, o_wdata[i],     q[i][0].wdata);
                end else begin
                    chk("out_wreg_empty", i, 64'(o_wreg[i]), 64'd0);
                end
                if (flush) begin
                    q[i].delete();
                end else begin
                    if (out_ready && sz != 0) void'(q[i].pop_front());
                    if (in_valid && rdy) q[i].push_back('{wd: in_wd, wreg: in_wreg, wdata: in_wdata});
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] wd, input logic [1:0] wr, input logic [63:0] d);
        in_valid = v;
        in_wd    = wd;
        in_wreg  = wr;
        in_wdata = d;
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;
        cyc(1);

        // Single push, drained next cycle.
        out_ready = 1'b1;
        drive(1'b1, {5'd0, 5'd5}, 2'b01, {32'h0, 32'h1234_5678});
        cyc(1);
        drive(1'b0, '0, '0, '0);
        cyc(3);

        // Fill to full with out_ready low, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 10'd1, 2'b11, 64'h11);
        cyc(1);
        drive(1'b1, 10'd2, 2'b11, 64'h22);
        cyc(1);
        drive(1'b1, 10'd3, 2'b11, 64'h33);
        cyc(1);
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        cyc(4);

        // Stall blocks push while the buffer drains.
        out_ready = 1'b0;
        drive(1'b1, 10'd7, 2'b10, 64'hA1);
        cyc(1);
        drive(1'b1, 10'd8, 2'b00, 64'hA2);
        cyc(1);
        stall = 6'b010000;
        out_ready = 1'b1;
        drive(1'b1, 10'd9, 2'b11, 64'hDEAD);
        cyc(3);
        stall = '0;
        drive(1'b0, '0, '0, '0);
        cyc(1);

        // Flush together with push and pop on a one-entry buffer.
        out_ready = 1'b0;
        drive(1'b1, 10'd4, 2'b01, 64'hB1);
        cyc(1);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 10'd5, 2'b11, 64'hBAD);
        cyc(1);
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        cyc(2);

        // Back-to-back push/pop exercising pointer wrap.
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 10'(k), 2'b01, 64'(k));
            cyc(1);
        end
        drive(1'b0, '0, '0, '0);
        cyc(2);

        // Randomised traffic with occasional stall and flush.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            stall     = (($urandom % 6) == 0) ? (6'($urandom) | 6'b010000) : (6'($urandom) & 6'b101111);
            flush     = ($urandom % 30) == 0;
            in_wd     = 10'($urandom);
            in_wreg   = 2'($urandom);
            in_wdata  = {$urandom, $urandom};
            cyc(1);
        end
        stall = '0;
        flush = 1'b0;

        // Asynchronous reset between edges with two entries held.
        out_ready = 1'b0;
        drive(1'b1, 10'd11, 2'b11, 64'hC1);
        cyc(1);
        drive(1'b1, 10'd12, 2'b11, 64'hC2);
        cyc(1);
        drive(1'b0, '0, '0, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        out_ready = 1'b1;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_buf

`default_nettype wire

// File: doc/mem_wb_buf.md
# mem_wb_buf

Parametrised MEM/WB pipeline stage. It replaces the single-entry MEM/WB register with a small in-order buffer that carries `NUM_CH` independent write-back channels (GPR plus HI/LO, for example). It adds valid/ready flow control toward the write-back port, a flush input, and a full-indication stall request to `ctrl`. It sits between the MEM stage and the register-file/HI-LO write ports, and honours the global `stall[5:0]` vector.

## Interface
Parameters:
- `DATA_W`, 32: data width per channel.
- `ADDR_W`, 5: destination address width per channel.
- `NUM_CH`, 2: number of write-back channels; legal range 1..4.
- `DEPTH`, 2: buffer entries; legal range 1..4.
- `STALL_BIT`, 4: index of `stall` that freezes the MEM-side push.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Asserted when 0.
- `stall`, in, 6: global stall vector from `ctrl`.
- `flush`, in, 1: discard all buffered entries.
- `in_valid`, in, 1: MEM stage presents a result.
- `in_ready`, out, 1: buffer accepts a push this cycle.
- `in_wd`, in, `NUM_CH*ADDR_W`: destination addresses. Channel k occupies `[k*ADDR_W +: ADDR_W]`.
- `in_wreg`, in, `NUM_CH`: per-channel write enables.
- `in_wdata`, in, `NUM_CH*DATA_W`: per-channel data.
- `out_valid`, out, 1: head entry is valid.
- `out_ready`, in, 1: write-back side consumes the head.
- `out_wd`, out, `NUM_CH*ADDR_W`: head addresses.
- `out_wreg`, out, `NUM_CH`: head write enables, gated by `out_valid`.
- `out_wdata`, out, `NUM_CH*DATA_W`: head data.
- `count`, out, `$clog2(DEPTH+1)`: number of occupied entries.
- `stallreq`, out, 1: buffer full; routed to `ctrl`.

## Operation
- Storage is a circular buffer of `DEPTH` entries. Each entry is {wd, wreg, wdata} for all channels.
- Pointers: `wr_ptr` and `rd_ptr` wrap modulo `DEPTH`, including non-power-of-two `DEPTH`. Occupancy is held in a separate counter `cnt`.
- Control equations:
  - `in_ready = (cnt != DEPTH) && (stall[STALL_BIT] == 0) && !flush`
  - `push = in_valid && in_ready`
  - `pop = out_valid && out_ready && !flush`
- Push writes the entry at `wr_ptr`, then increments `wr_ptr`. Pop increments `rd_ptr`.
- Occupancy update:
  - push and pop together: `cnt` unchanged.
  - push only: `cnt + 1`.
  - pop only: `cnt - 1`.
- A push while full is impossible by construction. A pop while empty is ignored.
- `flush` forces `cnt`, `wr_ptr` and `rd_ptr` to 0 on the next edge. It overrides push and pop in the same cycle; storage contents are don't-care.
- `out_valid = (cnt != 0)`.
- `out_wd` and `out_wdata` present the entry at `rd_ptr`.
- `out_wreg = out_valid ? entry.wreg : 0`. An empty buffer never produces a write enable.
- `stallreq = (cnt == DEPTH)`.
- An entry with `in_valid=1` and all `in_wreg=0` (a bubble) is still buffered and popped. Ordering is strictly preserved.
- `stall[STALL_BIT]=1` blocks push only. Pops continue, so the buffer drains while the MEM side is frozen.

## Timing
- Reset: `cnt=0`, pointers 0, `out_valid=0`, `out_wreg=0`, `out_wd=0` (`NOPRegAddr`), `out_wdata=0` (`ZeroWord`), `stallreq=0`, `count=0`. Storage is cleared to zero.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (`out_valid=1`), one cycle after `in_valid`. This matches the old register.
- Throughput is one entry per cycle when `out_ready` is held high.
- `in_ready` is combinational from registered state plus `stall` and `flush`. There is no combinational path from `out_ready` to `in_ready`, so a full buffer cannot push and pop in the same cycle.
- `out_*` are driven from registers through a read mux. There is no path from the `in_*` ports to the `out_*` ports.

## Structure
- Add to `defines.v`: `MEMWB_DEPTH_MAX` (4) and `MEMWB_CH_MAX` (4). Reuse the existing `NOPRegAddr`, `ZeroWord`, `WriteDisable`.
- Add a sub-module `pipe_fifo_ctrl`: pointer and counter logic, parametrised by `DEPTH`, producing `wr_ptr`, `rd_ptr`, `cnt`, full and empty.
- The data array and output mux stay in `mem_wb_buf`.

## Test plan
- Reset, then one push: ch0 {wd=5, wreg=1, wdata=0x1234_5678}, ch1 wreg=0, `out_ready=1`. Required: `out_valid=1` with those values one cycle later, `count=1`, then empty the following cycle.
- `out_ready=0`, three pushes of 0x11, 0x22, 0x33 with `DEPTH=2`. Required: `count=2`, `stallreq=1`, `in_ready=0`; the third value is not accepted. Raise `out_ready`: values appear in the order 0x11, 0x22.
- `stall=6'b010000`, `in_valid=1`, buffer holding 2 entries, `out_ready=1`. Required: no push, and the buffer drains to `count=0` in 2 cycles.
- `flush=1` together with push and pop on a buffer of 1 entry. Required: `count=0`, `out_wreg=0` on the next cycle, and the pushed data never appears.
- `DEPTH=3`, 10 back-to-back push/pop pairs with data 1..10. Required: output sequence 1..10 and pointer wrap verified; `count` stays at 1.
- `rst` driven low between clock edges while `count=2`. Required: outputs go to reset values immediately, with `out_wreg=0` before the next edge.
